pwm_breath_sequencer: RTL and testbench

PWM_BREATH_SEQUENCER -- requirements
Module: pwm_breath_sequencer

---
 rtl/pwm_breath_sequencer_if.sv | 21 ++
 rtl/pwm_breath_sequencer.sv | 75 +++++++
 tb/tb_pwm_breath_sequencer.sv | 139 +++++++++++++
 3 files changed

// File: rtl/pwm_breath_sequencer_if.sv
// pwm_breath_sequencer_if: control and compare bundle between a breath sequencer and its PWM core
//
// Signals (named from the sequencer's point of view):
//   i_enable   1             sequencer runs while high, freezes while low
//   i_mode     2*CHANNELS    per-channel mode, channel k at [2k+1:2k]
//   o_top      TOP_WIDTH     PWM counter top value (all ones)
//   o_compare  CW*CHANNELS   per-channel compare, CW = TOP_WIDTH+1
//   o_valid    1             single-cycle load strobe for o_top/o_compare
// Modports: slave = sequencer, master = controller / PWM core side.
interface pwm_breath_sequencer_if #(
    parameter int CHANNELS  = 3,
    parameter int TOP_WIDTH = 8
);
    logic                               i_enable;
    logic [2*CHANNELS-1:0]              i_mode;
    logic [TOP_WIDTH-1:0]               o_top;
    logic [(TOP_WIDTH+1)*CHANNELS-1:0]  o_compare;
    logic                               o_valid;
    modport master (output i_enable, i_mode, input o_top, o_compare, o_valid);
    modport slave  (input i_enable, i_mode, output o_top, o_compare, o_valid);
endinterface

// File: rtl/pwm_breath_sequencer.sv
// pwm_breath_sequencer: multi-channel breathing-LED compare generator feeding a PWM core
//
// Ports:
//   i_clk  sole clock, rising edge
//   i_rst  asynchronous active-high reset
//   bus    pwm_breath_sequencer_if.slave (i_enable, i_mode, o_top, o_compare, o_valid)
//
// A shared step counter divides the clock by STEP. Every step tick each channel's
// ramp advances 0..FULL; when it wraps, the channel's 2-bit phase advances. The
// latched mode turns (ramp, phase) into a compare value. Ramp and phase advance in
// every mode so the quarter-period stagger between channels survives mode changes.
module pwm_breath_sequencer #(
    parameter int CHANNELS  = 3,
    parameter int TOP_WIDTH = 8,
    parameter int STEP      = 97_276
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    pwm_breath_sequencer_if.slave bus
);
    localparam int CW = TOP_WIDTH + 1;
    localparam int SW = $clog2(STEP);
    localparam logic [CW-1:0] FULL = {1'b1, {TOP_WIDTH{1'b0}}};
    localparam logic [SW-1:0] LAST = SW'(STEP - 1);

    localparam logic [1:0] MODE_OFF  = 2'd0;
    localparam logic [1:0] MODE_TRI  = 2'd1;
    localparam logic [1:0] MODE_SAW  = 2'd2;
    localparam logic [1:0] MODE_FULL = 2'd3;

    localparam logic [1:0] PH_LOW  = 2'd0;
    localparam logic [1:0] PH_RISE = 2'd1;
    localparam logic [1:0] PH_HIGH = 2'd2;

    logic [SW-1:0]                r_cnt;
    logic [CHANNELS-1:0][CW-1:0]  r_ramp;
    logic [CHANNELS-1:0][1:0]     r_phase;
    logic [CHANNELS-1:0][1:0]     r_mode;
    logic [CHANNELS-1:0][CW-1:0]  w_cmp;

    // Reset phase k mod 4 staggers channels by a quarter period.
    always_ff @(posedge i_clk or posedge i_rst)
        if (i_rst) begin
            r_cnt <= '0;
            for (int k = 0; k < CHANNELS; k++) begin
                r_ramp[k]  <= '0;
                r_phase[k] <= 2'(k % 4);
                r_mode[k]  <= MODE_TRI;
            end
        end else if (bus.i_enable) begin
            r_cnt <= (r_cnt == LAST) ? '0 : r_cnt + 1'b1;
            if (r_cnt == LAST)
                for (int k = 0; k < CHANNELS; k++) begin
                    r_ramp[k]  <= (r_ramp[k] == FULL) ? '0 : r_ramp[k] + 1'b1;
                    r_phase[k] <= (r_ramp[k] == FULL) ? r_phase[k] + 2'd1 : r_phase[k];
                    r_mode[k]  <= bus.i_mode[2*k +: 2];
                end
        end

    // FULL - ramp cannot underflow because ramp never exceeds FULL.
    always_comb begin
        w_cmp = '0;
        for (int k = 0; k < CHANNELS; k++)
            w_cmp[k] = (r_mode[k] == MODE_OFF)  ? '0 :
                       (r_mode[k] == MODE_SAW)  ? r_ramp[k] :
                       (r_mode[k] == MODE_FULL) ? FULL :
                       (r_phase[k] == PH_LOW)   ? '0 :
                       (r_phase[k] == PH_RISE)  ? r_ramp[k] :
                       (r_phase[k] == PH_HIGH)  ? FULL : FULL - r_ramp[k];
    end

    assign bus.o_top     = '1;
    assign bus.o_compare = w_cmp;
    assign bus.o_valid   = bus.i_enable && (r_cnt == '0);
endmodule

// File: tb/tb_pwm_breath_sequencer.sv
// tb_pwm_breath_sequencer: directed scoreboard bench for pwm_breath_sequencer
module tb_pwm_breath_sequencer;
    localparam int CH = 2;
    localparam int TW = 2;
    localparam int ST = 4;
    localparam int CW = TW + 1;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    pwm_breath_sequencer_if #(.CHANNELS(CH), .TOP_WIDTH(TW)) bus();
    pwm_breath_sequencer #(.CHANNELS(CH), .TOP_WIDTH(TW), .STEP(ST)) dut (
        .i_clk(clk), .i_rst(rst), .bus(bus));

    pwm_breath_sequencer_if dbus();
    pwm_breath_sequencer ddut (.i_clk(clk), .i_rst(rst), .bus(dbus));

    int total = 0;
    int bad = 0;
    int m_cnt;
    int m_ticks;
    logic [1:0] m_mode [CH];
    logic [CW*CH-1:0] exp_q [$];
    int tri_tab [20] = '{0,0,0,0,0, 0,1,2,3,4, 4,4,4,4,4, 4,3,2,1,0};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [CW*CH-1:0] exp_all();
        logic [CW*CH-1:0] v;
        int pos;
        v = '0;
        for (int k = 0; k < CH; k++) begin
            pos = (5*k + m_ticks) % 20;
            case (m_mode[k])
                2'd0: v[k*CW +: CW] = '0;
                2'd1: v[k*CW +: CW] = CW'(tri_tab[pos]);
                2'd2: v[k*CW +: CW] = CW'(pos % 5);
                default: v[k*CW +: CW] = CW'(4);
            endcase
        end
        return v;
    endfunction

    task automatic model_reset();
        m_cnt = 0;
        m_ticks = 0;
        for (int k = 0; k < CH; k++) m_mode[k] = 2'd1;
        exp_q.delete();
    endtask

    task automatic cycle_check();
        logic ev;
        ev = bus.i_enable && (m_cnt == 0);
        chk("valid", 32'(bus.o_valid), 32'(ev));
        chk("compare", 32'(bus.o_compare), 32'(exp_all()));
        if (ev) exp_q.push_back(exp_all());
        if (bus.o_valid) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $error("FAIL sb_empty got=valid exp=none");
            end else chk("sb_load", 32'(bus.o_compare), 32'(exp_q.pop_front()));
        end
    endtask

    task automatic run(input int n);
        repeat (n) begin
            cycle_check();
            @(posedge clk);
            if (bus.i_enable) begin
                if (m_cnt == ST - 1) begin
                    m_ticks++;
                    for (int k = 0; k < CH; k++) m_mode[k] = bus.i_mode[2*k +: 2];
                end
                m_cnt = (m_cnt + 1) % ST;
            end
            @(negedge clk);
        end
    endtask

    task automatic run_until_cnt(input int c);
        for (int i = 0; i < 40 && m_cnt != c; i++) run(1);
        chk("reach_cnt", 32'(m_cnt), 32'(c));
    endtask

    initial begin
        bus.i_enable = 1'b1;
        bus.i_mode = 4'b0101;
        dbus.i_enable = 1'b0;
        dbus.i_mode = '0;
        model_reset();
        #1 rst = 1'b1;
        #1;
        chk("rst_top", 32'(bus.o_top), 32'h3);
        chk("rst_cmp", 32'(bus.o_compare), 32'h0);
        chk("rst_valid", 32'(bus.o_valid), 32'h1);
        chk("def_top", 32'(dbus.o_top), 32'hFF);
        chk("def_ch0", 32'(dbus.o_compare[8:0]), 32'h0);
        chk("def_ch1", 32'(dbus.o_compare[17:9]), 32'h0);
        chk("def_ch2", 32'(dbus.o_compare[26:18]), 32'h100);
        chk("def_valid", 32'(dbus.o_valid), 32'h0);
        @(negedge clk);
        chk("rst_hold_cmp", 32'(bus.o_compare), 32'h0);
        rst = 1'b0;
        model_reset();
        run(160);
        chk("wrap_ch0", 32'(bus.o_compare[CW-1:0]), 32'h0);
        chk("wrap_ticks", 32'(m_ticks), 32'd40);
        bus.i_mode = 4'b0110;
        run(48);
        run_until_cnt(2);
        bus.i_mode = 4'b0111;
        run(40);
        bus.i_mode = 4'b0101;
        run_until_cnt(2);
        bus.i_enable = 1'b0;
        run(7);
        bus.i_enable = 1'b1;
        run(24);
        for (int i = 0; i < 200 && !((m_ticks % 20) == 17 && m_cnt == 2); i++) run(1);
        chk("pre_rst_ch0", 32'(bus.o_compare[CW-1:0]), 32'h2);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_cmp", 32'(bus.o_compare), 32'h0);
        chk("async_rst_valid", 32'(bus.o_valid), 32'h1);
        #1 rst = 1'b0;
        model_reset();
        run(40);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
